// File: rtl/intl_trip_mgr_pkg.sv
// ---------------------------------------------------------------------------
// intl_trip_mgr_pkg
// Shared interlock definitions: trip-manager state encodings, default source
// count, field widths, the source-index map of the detectors that feed the
// trip manager, and a lowest-set-bit helper used for first-fault capture.
// ---------------------------------------------------------------------------
package intl_trip_mgr_pkg;

    localparam int unsigned N_SRC_DEF = 8;   // default number of interlock sources
    localparam int unsigned FILT_W    = 16;  // debounce counter / threshold width
    localparam int unsigned TS_W      = 32;  // timestamp width
    localparam int unsigned IDX_W     = 5;   // source index width (up to 32 sources)

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_TRIP  = 2'd1,
        ST_LATCH = 2'd2,
        ST_CLEAR = 2'd3
    } intl_state_e;

    // Source-index map of the upstream detectors.
    localparam int unsigned SRC_OVERCURRENT = 0;
    localparam int unsigned SRC_OVERVOLTAGE = 1;
    localparam int unsigned SRC_UNDERVOLT   = 2;
    localparam int unsigned SRC_OVERTEMP    = 3;
    localparam int unsigned SRC_ARC         = 4;
    localparam int unsigned SRC_VACUUM      = 5;
    localparam int unsigned SRC_EXT_CHAIN   = 6;
    localparam int unsigned SRC_OSC         = 7;  // oscillation detector

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [31:0] vec);
        lowest_set = '0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) lowest_set = IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/intl_debounce.sv
// ---------------------------------------------------------------------------
// intl_debounce
// Single-source interlock qualifier. A flag must be held (and unmasked) for
// i_thresh+1 consecutive cycles before o_q asserts; any drop or mask resets
// the run. i_clr is a synchronous reset used by the clear sequence.
// Ports:
//   i_clk, i_rst  clock, async active-low reset
//   i_clr         synchronous filter clear
//   i_flag        level flag from the detector
//   i_mask        1 = source ignored
//   i_thresh      debounce length in cycles (0 = qualify on first cycle)
//   o_q           qualified fault
// ---------------------------------------------------------------------------
module intl_debounce
    import intl_trip_mgr_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_flag,
    input  logic              i_mask,
    input  logic [FILT_W-1:0] i_thresh,
    output logic              o_q
);

    logic [FILT_W-1:0] cnt;
    logic              active;

    assign active = i_flag & ~i_mask;

    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt <= '0;
            o_q <= 1'b0;
        end else if (i_clr || !active) begin
            cnt <= '0;
            o_q <= 1'b0;
        end else begin
            if (cnt < i_thresh) cnt <= cnt + FILT_W'(1);
            // >= rather than == so that lowering the threshold mid-run still
            // qualifies a counter that already sits above the new value.
            if (cnt >= i_thresh) o_q <= 1'b1;
        end
    end

endmodule

// File: rtl/intl_trip_mgr.sv
// ---------------------------------------------------------------------------
// intl_trip_mgr
// Interlock trip manager. Debounces N_SRC detector flags, trips on the first
// qualified source, latches its index and a timestamp, holds the aggregate
// interlock until an operator clear, then runs a timed clear sequence that
// pulses the detectors' clear inputs.
// Ports:
//   i_clk, i_rst      clock, async active-low reset
//   i_intl_flag       per-source level flags
//   i_intl_mask       per-source mask (1 = ignored)
//   i_filt_thresh     debounce length in cycles
//   i_clr             operator clear request (acted on in LATCH only)
//   o_intl            aggregate interlock, 1 = power stage disabled
//   o_clr             one-cycle clear pulse to upstream detectors
//   o_fault_latched   sticky OR of qualified sources since the last clear
//   o_first_idx       index of the first qualified source
//   o_fault_time      timestamp at the trip
//   o_state           current state (RUN/TRIP/LATCH/CLEAR)
// ---------------------------------------------------------------------------
module intl_trip_mgr
    import intl_trip_mgr_pkg::*;
#(
    parameter int unsigned N_SRC    = N_SRC_DEF,
    parameter int unsigned CLR_WAIT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_SRC-1:0]  i_intl_flag,
    input  logic [N_SRC-1:0]  i_intl_mask,
    input  logic [FILT_W-1:0] i_filt_thresh,
    input  logic              i_clr,
    output logic              o_intl,
    output logic              o_clr,
    output logic [N_SRC-1:0]  o_fault_latched,
    output logic [IDX_W-1:0]  o_first_idx,
    output logic [TS_W-1:0]   o_fault_time,
    output logic [1:0]        o_state
);

    localparam int unsigned WAIT_W = (CLR_WAIT > 1) ? $clog2(CLR_WAIT) : 1;

    intl_state_e       state_q, state_d;
    logic [N_SRC-1:0]  q;
    logic [31:0]       q_ext;
    logic [TS_W-1:0]   ts;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_done;
    logic              trip_entry, clr_entry, accumulate, intl_d;

    // Filters are held in reset during the first CLEAR cycle only, which is
    // exactly the cycle o_clr is high.
    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        intl_debounce u_debounce (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_clr    (o_clr),
            .i_flag   (i_intl_flag[g]),
            .i_mask   (i_intl_mask[g]),
            .i_thresh (i_filt_thresh),
            .o_q      (q[g])
        );
    end

    always_comb begin
        q_ext            = '0;
        q_ext[N_SRC-1:0] = q;
    end

    assign wait_done = (wait_cnt == WAIT_W'(CLR_WAIT - 1));

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // Next-state logic
    // NOTE: default assignment first so every path drives state_d and no
    // latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:   if (|q)       state_d = ST_TRIP;
            ST_TRIP:                state_d = ST_LATCH;
            ST_LATCH: if (i_clr)    state_d = ST_CLEAR;
            ST_CLEAR: if (wait_done) state_d = ST_RUN;
            default:                state_d = ST_RUN;
        endcase
    end

    // Output decode, registered below so every output comes from a flop.
    always_comb begin
        intl_d     = (state_d != ST_RUN);
        trip_entry = (state_q == ST_RUN)   && (state_d == ST_TRIP);
        clr_entry  = (state_q == ST_LATCH) && (state_d == ST_CLEAR);
        accumulate = ((state_q == ST_TRIP) || (state_q == ST_LATCH)) && !clr_entry;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_intl          <= 1'b0;
            o_clr           <= 1'b0;
            o_fault_latched <= '0;
            o_first_idx     <= '0;
            o_fault_time    <= '0;
            wait_cnt        <= '0;
            ts              <= '0;
        end else begin
            o_intl <= intl_d;
            o_clr  <= clr_entry;
            ts     <= ts + TS_W'(1);

            if (trip_entry) begin
                o_fault_latched <= q;
                o_first_idx     <= lowest_set(q_ext);
                o_fault_time    <= ts;
            end else if (clr_entry) begin
                o_fault_latched <= '0;
                o_first_idx     <= '0;
                o_fault_time    <= '0;
            end else if (accumulate) begin
                o_fault_latched <= o_fault_latched | q;
            end

            if (clr_entry)
                wait_cnt <= '0;
            else if (state_q == ST_CLEAR && !wait_done)
                wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_intl_trip_mgr.sv
module tb_intl_trip_mgr;
    import intl_trip_mgr_pkg::*;

    localparam int N        = 8;
    localparam int CLR_WAIT = 16;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [N-1:0]  flag, mask;
    logic [15:0]   thresh;
    logic          clr;
    logic          o_intl, o_clr;
    logic [N-1:0]  o_lat;
    logic [4:0]    o_idx;
    logic [31:0]   o_time;
    logic [1:0]    o_state;

    int checks = 0;
    int errors = 0;
    int unsigned cyc;

    intl_trip_mgr #(.N_SRC(N), .CLR_WAIT(CLR_WAIT)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_intl_flag(flag), .i_intl_mask(mask),
        .i_filt_thresh(thresh), .i_clr(clr), .o_intl(o_intl), .o_clr(o_clr),
        .o_fault_latched(o_lat), .o_first_idx(o_idx), .o_fault_time(o_time),
        .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- behavioural reference model ----------------
    // Qualification: a source qualifies once it has been active (flag & ~mask)
    // for more than thresh consecutive sampled edges since the last clear.
    int          m_run[N];
    bit [N-1:0]  m_q, m_lat;
    int          m_state, m_idx, m_left;
    bit          m_intl, m_clr;
    bit [31:0]   m_time, m_ts;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m_run[i] = 0;
        m_q = '0; m_lat = '0; m_state = 0; m_idx = 0; m_left = 0;
        m_intl = 0; m_clr = 0; m_time = 0; m_ts = 0;
    endfunction

    function automatic void model_edge();
        bit [N-1:0] q_pre   = m_q;
        bit         clr_pre = m_clr;
        int         nxt     = m_state;
        m_clr = 0;
        case (m_state)
            0: if (q_pre != 0) begin
                nxt = 1; m_lat = q_pre; m_time = m_ts;
                for (int i = N - 1; i >= 0; i--) if (q_pre[i]) m_idx = i;
            end
            1: begin m_lat |= q_pre; nxt = 2; end
            2: if (clr) begin
                nxt = 3; m_clr = 1; m_lat = '0; m_idx = 0; m_time = 0;
                m_left = CLR_WAIT - 1;
            end else m_lat |= q_pre;
            default: if (m_left == 0) nxt = 0; else m_left--;
        endcase
        for (int i = 0; i < N; i++) begin
            if (clr_pre || !(flag[i] && !mask[i])) m_run[i] = 0;
            else if (m_run[i] < 100000) m_run[i]++;
            m_q[i] = (m_run[i] > int'(thresh));
        end
        m_intl  = (nxt != 0);
        m_state = nxt;
        m_ts++;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] st, input logic intl,
                             input logic oc, input logic [N-1:0] lat, input logic [4:0] idx,
                             input logic [31:0] tm, input bit chk_tm);
        check({tag, ".state"}, 32'(o_state), 32'(st));
        check({tag, ".intl"},  32'(o_intl),  32'(intl));
        check({tag, ".clr"},   32'(o_clr),   32'(oc));
        check({tag, ".lat"},   32'(o_lat),   32'(lat));
        check({tag, ".idx"},   32'(o_idx),   32'(idx));
        if (chk_tm) check({tag, ".time"}, o_time, tm);
    endtask

    // One clock: inputs were set at the preceding negedge; outputs are
    // sampled at the following negedge.
    task automatic tick();
        @(posedge i_clk);
        model_edge();
        cyc++;
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b0; flag = '0; mask = '0; clr = 1'b0;
        model_reset(); cyc = 0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [N-1:0] flag;
        logic [N-1:0] mask;
        logic [15:0]  thresh;
        logic         clr;
        int           reps;
        logic [1:0]   st;
        logic         intl;
        logic         oclr;
        logic [N-1:0] lat;
        logic [4:0]   idx;
    } vec_t;

    vec_t tbl[9];
    int   n;

    initial begin
        flag = '0; mask = '0; thresh = '0; clr = 1'b0; i_rst = 1'b0;
        model_reset(); cyc = 0;
        #12;
        check_all("reset", ST_RUN, 0, 0, '0, 0, 0, 1);
        @(negedge i_clk);
        i_rst = 1'b1;

        // thresh=3: flag[2] 4 cycles trips, clear sequence, then a 3-cycle pulse
        tbl[0] = '{8'h04, 8'h00, 16'd3, 1'b0, 4,  ST_RUN,   0, 0, 8'h00, 5'd0};
        tbl[1] = '{8'h00, 8'h00, 16'd3, 1'b0, 1,  ST_TRIP,  1, 0, 8'h04, 5'd2};
        tbl[2] = '{8'h00, 8'h00, 16'd3, 1'b0, 1,  ST_LATCH, 1, 0, 8'h04, 5'd2};
        tbl[3] = '{8'h00, 8'h00, 16'd3, 1'b1, 1,  ST_CLEAR, 1, 1, 8'h00, 5'd0};
        tbl[4] = '{8'h00, 8'h00, 16'd3, 1'b0, 1,  ST_CLEAR, 1, 0, 8'h00, 5'd0};
        tbl[5] = '{8'h00, 8'h00, 16'd3, 1'b0, 14, ST_CLEAR, 1, 0, 8'h00, 5'd0};
        tbl[6] = '{8'h00, 8'h00, 16'd3, 1'b0, 1,  ST_RUN,   0, 0, 8'h00, 5'd0};
        tbl[7] = '{8'h04, 8'h00, 16'd3, 1'b0, 3,  ST_RUN,   0, 0, 8'h00, 5'd0};
        tbl[8] = '{8'h00, 8'h00, 16'd3, 1'b0, 3,  ST_RUN,   0, 0, 8'h00, 5'd0};

        for (int v = 0; v < 9; v++) begin
            for (int r = 0; r < tbl[v].reps; r++) begin
                flag = tbl[v].flag; mask = tbl[v].mask;
                thresh = tbl[v].thresh; clr = tbl[v].clr;
                tick();
                check_all($sformatf("vec%0d.%0d", v, r), tbl[v].st, tbl[v].intl,
                          tbl[v].oclr, tbl[v].lat, tbl[v].idx, 0, 0);
            end
        end
        clr = 1'b0;

        // ---- A: thresh=0, flags 1 and 5 together ----
        thresh = 16'd0; flag = 8'h22;
        tick();
        check("A.q_cycle_state", 32'(o_state), 32'(ST_RUN));
        tick();
        check_all("A.trip", ST_TRIP, 1, 0, 8'h22, 5'd1, cyc - 1, 1);
        tick();
        flag = 8'h00;
        tick();
        check_all("A.latch", ST_LATCH, 1, 0, 8'h22, 5'd1, cyc - 3, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_all("A.clr_entry", ST_CLEAR, 1, 1, '0, 0, 0, 1);
        n = 0;
        begin
            int clr_hi = 0;
            while (o_state == ST_CLEAR && n < 40) begin
                tick(); n++;
                if (o_clr) clr_hi++;
            end
            check("A.clr_extra_high_cycles", 32'(clr_hi), 0);
        end
        check("A.clear_wait_cycles", 32'(n), 32'(CLR_WAIT));
        check_all("A.run", ST_RUN, 0, 0, '0, 0, 0, 1);

        // ---- B: flag[0] held through the clear re-trips once RUN is reached ----
        thresh = 16'd3; flag = 8'h01;
        n = 0;
        while (o_state != ST_TRIP && n < 20) begin tick(); n++; end
        check("B.trip_latency", 32'(n), 32'(3 + 2));
        check_all("B.trip", ST_TRIP, 1, 0, 8'h01, 0, cyc - 1, 1);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_all("B.clr_entry", ST_CLEAR, 1, 1, '0, 0, 0, 1);
        n = 0;
        while (o_state == ST_CLEAR && n < 40) begin tick(); n++; end
        check("B.clear_wait_cycles", 32'(n), 32'(CLR_WAIT));
        check_all("B.run", ST_RUN, 0, 0, '0, 0, 0, 1);
        tick();
        check_all("B.retrip", ST_TRIP, 1, 0, 8'h01, 0, cyc - 1, 1);

        // ---- C: masked source never trips; LATCH immune to mask/thresh changes;
        //         reset mid-LATCH ----
        do_reset();
        thresh = 16'd0; mask = 8'h08; flag = 8'h08;
        begin
            int tripped = 0;
            for (int k = 0; k < 10; k++) begin
                tick();
                if (o_state != ST_RUN) tripped++;
            end
            check("C.masked_no_trip", 32'(tripped), 0);
        end
        check_all("C.masked_run", ST_RUN, 0, 0, '0, 0, 0, 1);
        flag = 8'h18;
        tick(); tick();
        check_all("C.trip", ST_TRIP, 1, 0, 8'h10, 5'd4, cyc - 1, 1);
        tick();
        mask = 8'hFF; thresh = 16'd9;
        tick();
        check_all("C.latch_after_mask", ST_LATCH, 1, 0, 8'h10, 5'd4, cyc - 3, 1);
        #2 i_rst = 1'b0;
        #1 check_all("C.async_reset", ST_RUN, 0, 0, '0, 0, 0, 1);
        flag = '0; mask = '0; clr = 1'b0;

        // ---- randomized run against the reference model ----
        do_reset();
        thresh = 16'($urandom_range(0, 4));
        for (int k = 0; k < 3000; k++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 11) == 0) flag[b] = ~flag[b];
                if ($urandom_range(0, 99) == 0) mask[b] = ~mask[b];
            end
            clr = ($urandom_range(0, 5) == 0);
            tick();
            check_all($sformatf("rnd%0d", k), 2'(m_state), m_intl, m_clr, m_lat,
                      5'(m_idx), m_time, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
